// File: rtl/vend_sequencer.sv
// Coin-operated vending transaction controller: credit accumulation, priced selection,
// vend request/acknowledge handshake and one-coin-per-cycle change payout.
module vend_sequencer #(
    parameter int MAX_CREDIT = 8,
    parameter int PRICE0     = 5,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 3,
    parameter int PRICE3     = 2,
    parameter int TIMEOUT    = 255,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    in,
    input  logic          sel_valid,
    input  logic [1:0]    sel,
    input  logic          cancel,
    input  logic          vend_ack,
    output logic          vend_req,
    output logic [1:0]    vend_id,
    output logic          chg10,
    output logic          chg5,
    output logic          coin_rej,
    output logic          sel_err,
    output logic [CW-1:0] credit,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] credit_q,   credit_d;
    logic [TW-1:0] cnt_q,      cnt_d;
    logic          vend_req_q, vend_req_d;
    logic [1:0]    vend_id_q,  vend_id_d;
    logic          chg10_q,    chg10_d;
    logic          chg5_q,     chg5_d;
    logic          coin_rej_q, coin_rej_d;
    logic          sel_err_q,  sel_err_d;
    logic          busy_q,     busy_d;

    logic [CW-1:0] coin_val;
    logic [CW:0]   coin_sum;
    logic [CW-1:0] price;
    logic          coin_accept;

    always_comb begin
        coin_val = '0;
        case (in)
            3'b001:  coin_val = CW'(1);
            3'b010:  coin_val = CW'(2);
            3'b011:  coin_val = CW'(3);
            3'b100:  coin_val = CW'(4);
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        price = CW'(PRICE0);
        case (sel)
            2'd0: price = CW'(PRICE0);
            2'd1: price = CW'(PRICE1);
            2'd2: price = CW'(PRICE2);
            2'd3: price = CW'(PRICE3);
            default: price = CW'(PRICE0);
        endcase
    end

    // Coins are only banked when the panel is not strobing a selection in the same cycle.
    assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_accept = (coin_val != '0) && !sel_valid
                       && ((state_q == S_IDLE) || (state_q == S_CREDIT))
                       && (coin_sum <= (CW+1)'(MAX_CREDIT));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        credit_d   = credit_q;
        cnt_d      = '0;
        vend_req_d = vend_req_q;
        vend_id_d  = vend_id_q;
        chg10_d    = 1'b0;
        chg5_d     = 1'b0;
        coin_rej_d = (in != 3'b000) && !coin_accept;
        sel_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_accept) begin
                    credit_d = coin_sum[CW-1:0];
                    state_d  = S_CREDIT;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    if (coin_accept) credit_d = coin_sum[CW-1:0];
                    state_d = S_CHANGE;
                end else if (sel_valid) begin
                    if (credit_q >= price) begin
                        credit_d   = credit_q - price;
                        vend_id_d  = sel;
                        vend_req_d = 1'b1;
                        state_d    = S_VEND;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (coin_accept) begin
                    credit_d = coin_sum[CW-1:0];
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_CHANGE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_VEND: begin
                if (vend_ack) begin
                    vend_req_d = 1'b0;
                    state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                if (credit_q >= CW'(2)) begin
                    chg10_d  = 1'b1;
                    credit_d = credit_q - CW'(2);
                end else if (credit_q == CW'(1)) begin
                    chg5_d   = 1'b1;
                    credit_d = '0;
                end
                if (credit_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            cnt_q      <= '0;
            vend_req_q <= 1'b0;
            vend_id_q  <= 2'd0;
            chg10_q    <= 1'b0;
            chg5_q     <= 1'b0;
            coin_rej_q <= 1'b0;
            sel_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            vend_req_q <= vend_req_d;
            vend_id_q  <= vend_id_d;
            chg10_q    <= chg10_d;
            chg5_q     <= chg5_d;
            coin_rej_q <= coin_rej_d;
            sel_err_q  <= sel_err_d;
            busy_q     <= busy_d;
        end
    end

    assign vend_req = vend_req_q;
    assign vend_id  = vend_id_q;
    assign chg10    = chg10_q;
    assign chg5     = chg5_q;
    assign coin_rej = coin_rej_q;
    assign sel_err  = sel_err_q;
    assign credit   = credit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural transaction model.
module tb_vend_sequencer;

    localparam int MAXC = 8;
    localparam int TMO  = 255;
    int price[4] = '{5, 4, 3, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       vend_ack;
    logic       vend_req;
    logic [1:0] vend_id;
    logic       chg10;
    logic       chg5;
    logic       coin_rej;
    logic       sel_err;
    logic [3:0] credit;
    logic       busy;

    always #5 clk = ~clk;

    vend_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in        (coin),
        .sel_valid (sel_valid),
        .sel       (sel),
        .cancel    (cancel),
        .vend_ack  (vend_ack),
        .vend_req  (vend_req),
        .vend_id   (vend_id),
        .chg10     (chg10),
        .chg5      (chg5),
        .coin_rej  (coin_rej),
        .sel_err   (sel_err),
        .credit    (credit),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: what the machine owes, what it is doing, and the pulses due.
    typedef enum int {M_IDLE, M_CREDIT, M_VEND, M_CHANGE} mode_t;
    mode_t m_mode;
    int    m_credit, m_quiet, e_id;
    bit    e_req, e_c10, e_c5, e_rej, e_err;

    typedef struct {
        logic [2:0]  c;
        logic        sv;
        logic [1:0]  s;
        logic        cn;
        logic        ack;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [11:0] vec(bit req, int id, bit c10, bit c5, bit rej, bit err,
                                        int cr, bit bz);
        return {req, 2'(id), c10, c5, rej, err, 4'(cr), bz};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {vend_req, vend_id, chg10, chg5, coin_rej, sel_err, credit, busy};
    endfunction

    function automatic logic [11:0] model_vec();
        return vec(e_req, e_id, e_c10, e_c5, e_rej, e_err, m_credit,
                   (m_mode == M_VEND) || (m_mode == M_CHANGE));
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (req,id,c10,c5,rej,err,credit,busy)", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_quiet = 0; e_id = 0;
        e_req = 0; e_c10 = 0; e_c5 = 0; e_rej = 0; e_err = 0;
    endtask

    task automatic model_step(int c, bit sv, int s, bit cn, bit ack);
        int units = (c >= 1 && c <= 4) ? c : 0;
        bit room  = (m_mode == M_IDLE || m_mode == M_CREDIT) && units > 0 && !sv
                    && (m_credit + units <= MAXC);
        e_rej = (c != 0) && !room;
        e_c10 = 0; e_c5 = 0; e_err = 0;
        if (room) m_credit += units;
        case (m_mode)
            M_IDLE: if (room) begin m_mode = M_CREDIT; m_quiet = 0; end
            M_CREDIT: begin
                if (cn) m_mode = M_CHANGE;
                else if (sv) begin
                    m_quiet = 0;
                    if (m_credit >= price[s]) begin
                        m_credit -= price[s]; e_id = s; e_req = 1; m_mode = M_VEND;
                    end else e_err = 1;
                end else if (room) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == TMO) m_mode = M_CHANGE;
                end
            end
            M_VEND: if (ack) begin e_req = 0; m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE; end
            M_CHANGE: begin
                if (m_credit >= 2) begin e_c10 = 1; m_credit -= 2; end
                else begin e_c5 = 1; m_credit -= 1; end
                if (m_credit == 0) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic apply(logic [2:0] c, logic sv, logic [1:0] s, logic cn, logic ack);
        coin = c; sel_valid = sv; sel = s; cancel = cn; vend_ack = ack;
        @(posedge clk);
        #1;
        model_step(int'(c), sv, int'(s), cn, ack);
        coin = 3'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0; vend_ack = 1'b0;
    endtask

    task automatic step(string name, logic [2:0] c, logic sv, logic [1:0] s, logic cn, logic ack);
        apply(c, sv, s, cn, ack);
        check(name, dut_vec(), model_vec());
    endtask

    function automatic vec_t mk(logic [2:0] c, logic sv, logic [1:0] s, logic cn, logic ack,
                                logic [11:0] exp);
        vec_t v;
        v.c = c; v.sv = sv; v.s = s; v.cn = cn; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0; coin = 3'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0; vend_ack = 1'b0;
        model_reset();
        #12;
        check("reset_state", dut_vec(), 12'h000);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", dut_vec(), 12'h000);

        //                c     sv s  cn ack      req id c10 c5 rej err cr busy
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, vec(0, 0, 0, 0, 0, 0, 2, 0)));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, vec(0, 0, 0, 0, 0, 0, 4, 0)));
        tbl.push_back(mk(3'd0, 1, 0, 0, 0, vec(0, 0, 0, 0, 0, 1, 4, 0)));
        tbl.push_back(mk(3'd1, 0, 0, 0, 0, vec(0, 0, 0, 0, 0, 0, 5, 0)));
        tbl.push_back(mk(3'd0, 1, 0, 0, 0, vec(1, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, vec(1, 0, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, vec(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, vec(0, 0, 0, 0, 0, 0, 4, 0)));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, vec(0, 0, 0, 0, 0, 0, 8, 0)));
        tbl.push_back(mk(3'd1, 0, 0, 0, 0, vec(0, 0, 0, 0, 1, 0, 8, 0)));
        tbl.push_back(mk(3'd5, 0, 0, 0, 0, vec(0, 0, 0, 0, 1, 0, 8, 0)));
        tbl.push_back(mk(3'd0, 1, 3, 0, 0, vec(1, 3, 0, 0, 0, 0, 6, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, vec(0, 3, 0, 0, 0, 0, 6, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 3, 1, 0, 0, 0, 4, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 3, 1, 0, 0, 0, 2, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 3, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 3, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, vec(0, 3, 0, 0, 0, 0, 4, 0)));
        tbl.push_back(mk(3'd1, 1, 2, 0, 0, vec(1, 2, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, vec(0, 2, 0, 0, 0, 0, 1, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 0, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, vec(0, 2, 0, 0, 0, 0, 3, 0)));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, vec(0, 2, 0, 0, 0, 0, 5, 0)));
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, vec(0, 2, 0, 0, 0, 0, 5, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 1, 0, 0, 0, 3, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 1, 0, 0, 0, 1, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 0, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, vec(0, 2, 0, 0, 0, 0, 3, 0)));
        tbl.push_back(mk(3'd0, 0, 0, 1, 0, vec(0, 2, 0, 0, 0, 0, 3, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 1, 0, 0, 0, 1, 1)));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, vec(0, 2, 0, 1, 0, 0, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].c, tbl[i].sv, tbl[i].s, tbl[i].cn, tbl[i].ack);
            check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // Timeout: 15 rs left untouched must come back as 10 + 5 after TMO quiet cycles.
        step("timeout_coin", 3'd3, 0, 0, 0, 0);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step("timeout_wait", 3'd0, 0, 0, 0, 0);
            if (chg10 === 1'b1) begin n = i; break; end
        end
        check("timeout_latency", 12'(n), 12'(TMO + 1));
        step("timeout_chg5", 3'd0, 0, 0, 0, 0);

        // A refused selection restarts the idle count.
        step("tmo_clear_coin", 3'd1, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step("tmo_clear_a", 3'd0, 0, 0, 0, 0);
        step("tmo_clear_sel", 3'd0, 1, 0, 0, 0);
        for (int i = 0; i < 200; i++) step("tmo_clear_b", 3'd0, 0, 0, 0, 0);
        check("tmo_clear_not_busy", {11'd0, busy}, 12'd0);
        for (int i = 0; i < 60; i++) step("tmo_clear_c", 3'd0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a vend.
        step("rv_coin", 3'd4, 0, 0, 0, 0);
        step("rv_sel", 3'd0, 1, 3, 0, 0);
        #2 rst = 1'b0;
        #1 check("rst_mid_vend", dut_vec(), 12'h000);
        model_reset();
        #2 rst = 1'b1;
        step("rv_resume", 3'd0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a change payout.
        step("rc_coin_a", 3'd4, 0, 0, 0, 0);
        step("rc_coin_b", 3'd4, 0, 0, 0, 0);
        step("rc_cancel", 3'd0, 0, 0, 1, 0);
        step("rc_first_pulse", 3'd0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 check("rst_mid_change", dut_vec(), 12'h000);
        model_reset();
        #2 rst = 1'b1;
        step("rc_resume", 3'd0, 0, 0, 0, 0);
        step("rc_new_coin", 3'd2, 0, 0, 0, 0);

        // Randomized traffic, with occasional quiet stretches long enough to time out.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] c;
            logic       sv, cn, ack;
            logic [1:0] s;
            if ($urandom_range(0, 599) == 0) begin
                for (int k = 0; k < TMO + 10; k++) step("rand_quiet", 3'd0, 0, 0, 0, 0);
            end
            c   = ($urandom_range(0, 99) < 20) ? 3'($urandom_range(1, 7)) : 3'd0;
            sv  = ($urandom_range(0, 99) < 12);
            s   = 2'($urandom_range(0, 3));
            cn  = ($urandom_range(0, 99) < 4);
            ack = ($urandom_range(0, 99) < 40);
            step("rand", c, sv, s, cn, ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the coin-operated vending datapath. It accumulates coin credit, checks product selections against per-product prices, runs a request/acknowledge handshake with the dispense mechanism, and pays out change one coin per cycle. It sits between the coin acceptor and selection panel on one side and the dispense motor and change hopper on the other. All money is counted in units of 5 rupees.

## Interface
- MAX_CREDIT, 8: maximum credit held, in 5-rupee units (8 = 40 rs).
- PRICE0..PRICE3, 5 / 4 / 3 / 2: product prices in units (25 / 20 / 15 / 10 rs); each must be 1..MAX_CREDIT.
- TIMEOUT, 255: idle cycles in CREDIT before an automatic refund.
- CW, 4: credit register width; must hold MAX_CREDIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in  in  3  coin code: 000 none, 001 5 rs, 010 10 rs, 011 15 rs, 100 20 rs; 101–111 invalid.
- sel_valid  in  1  one-cycle selection strobe.
- sel  in  2  product index, qualified by sel_valid.
- cancel  in  1  refund request.
- vend_ack  in  1  dispense mechanism done.
- vend_req  out  1  dispense request, level.
- vend_id  out  2  product being dispensed.
- chg10  out  1  one-cycle pulse: release one 10 rs coin.
- chg5  out  1  one-cycle pulse: release one 5 rs coin.
- coin_rej  out  1  one-cycle pulse: coin returned uncredited.
- sel_err  out  1  one-cycle pulse: selection refused, insufficient credit.
- credit  out  CW  current credit in units.
- busy  out  1  high in VEND or CHANGE.

## Operation
- States: IDLE (credit 0), CREDIT, VEND, CHANGE. All outputs are registered.
- Coin acceptance applies in IDLE and CREDIT only. Value v is 1–4 units. The CW+1-bit sum credit+v must be ≤ MAX_CREDIT; if so, credit becomes the sum and the state goes to CREDIT. Otherwise credit is unchanged and coin_rej pulses.
- Invalid codes, and any non-zero coin in VEND or CHANGE, pulse coin_rej.
- Selection applies in CREDIT only; it is ignored in other states. If credit ≥ PRICE[sel]: credit -= price, vend_id <= sel, vend_req <= 1, go to VEND. Otherwise sel_err pulses and the state stays CREDIT.
- Any non-zero coin in the same cycle as sel_valid is rejected via coin_rej, whether or not the selection is accepted.
- cancel in CREDIT goes to CHANGE. cancel beats a same-cycle sel_valid; sel_err is not raised. cancel is ignored in IDLE, VEND and CHANGE.
- VEND: vend_req stays high until vend_ack is sampled high. Then vend_req drops and the state goes to CHANGE if credit > 0, else IDLE. vend_ack outside VEND is ignored.
- CHANGE, each cycle:
  - credit ≥ 2: chg10 pulses, credit -= 2.
  - credit == 1: chg5 pulses, credit -= 1.
  - The cycle that makes credit 0 transitions to IDLE.
- Timeout: the idle counter clears on entry to CREDIT, on every accepted coin, and on every sel_valid. When it reaches TIMEOUT in CREDIT, the state goes to CHANGE.
- Reset: state IDLE; credit, counter, vend_req, vend_id, chg10, chg5, coin_rej, sel_err and busy all 0. Reset takes effect immediately and asynchronously, including mid-VEND or mid-CHANGE. Unpaid credit is lost.

## Timing
- Coin sampled at edge t: credit shows the new value after edge t. coin_rej is high for the cycle following edge t.
- Accepted selection at edge t: vend_req, vend_id and the reduced credit are visible after t.
- vend_ack sampled at edge t: vend_req is low after t. The first change pulse follows edge t+1.
- Change for N units takes ceil(N/2) consecutive pulse cycles, with no gaps.
- busy is high from the cycle after selection acceptance (or cancel/timeout) until IDLE is entered.
- Minimum vend cycle: selection, 1 cycle in VEND with vend_ack tied high, then IDLE.

## Test plan
- Coins 010, 010 (credit 4); sel=0 → sel_err, credit 4. Coin 001 → credit 5. sel=0 → vend_req=1, vend_id=0, credit 0. vend_ack → IDLE, no change pulses.
- Coins 100, 100 (credit 8); sel=3 → credit 6, vend. vend_ack → chg10 on 3 consecutive cycles, credit 0, IDLE.
- Credit 8, coin 001 → coin_rej, credit stays 8. Coin 101 → coin_rej. Coin 010 during VEND → coin_rej, credit unchanged.
- Coin 011, no activity for TIMEOUT cycles → chg10 then chg5, IDLE. Repeat with cancel after the coin → same refund within 3 cycles.
- Same-cycle sel_valid+cancel with credit 5 → full refund, no vend. Same-cycle coin 001 + valid sel → vend and coin_rej.
- Assert rst low mid-VEND and mid-CHANGE → vend_req, chg10, chg5 and credit drop to 0 without a clock edge. The block resumes in IDLE after release.
